// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one registered bitwise logic unit between N requesters.
//   Round-robin arbitration picks a requester in IDLE, its operands are
//   captured on that edge, the result is computed in EXEC, and it is held
//   in RESP until the consumer takes it. The requester that was just served
//   gets the lowest priority in the next arbitration.
//
// Parameters
//   N  number of requesters (2..8)
//   W  operand/result width
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester operation pending
//   op_a/op_b  operands, requester i at [i*W +: W]
//   opcode     opcodes, requester i at [i*3 +: 3]
//                0 AND, 1 OR, 2 NAND, 3 NOR, 4 XNOR, 5 XOR, 6 NOT(a), 7 illegal
//   gnt        one-hot single-cycle pulse: operands of that requester captured
//   res_valid  result available
//   res_data   result value
//   res_id     index of the requester that owns the result
//   res_err    opcode was illegal
//   res_ready  consumer accepts the result
module logic_unit_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    input  logic [N*3-1:0] opcode,
    output logic [N-1:0]   gnt,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic [2:0]     res_id,
    output logic           res_err,
    input  logic           res_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [2:0]     rr_ptr;

    logic           pick_vld;
    logic [2:0]     pick_idx;
    logic [N-1:0]   pick_onehot;
    logic [W-1:0]   pick_a;
    logic [W-1:0]   pick_b;
    logic [2:0]     pick_op;

    logic [W-1:0]   a_p0;
    logic [W-1:0]   b_p0;
    logic [2:0]     op_p0;
    logic [2:0]     idx_p0;

    logic [W:0]     eval_p0;

    // Returns {found, index} of the first set request at or after ptr,
    // wrapping modulo N. The loop runs from the farthest distance down so
    // the last hit (the closest one) is what remains.
    function automatic logic [3:0] rr_pick(input logic [N-1:0] r, input logic [2:0] ptr);
        logic [3:0]   sel;
        logic [N-1:0] rs;
        int           j;
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            rs = r >> j;
            if (rs[0]) sel = {1'b1, 3'(j)};
        end
        return sel;
    endfunction

    // Returns {err, data} for one bitwise operation.
    function automatic logic [W:0] lu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [W:0] r;
        case (op)
            3'd0:    r = {1'b0, a & b};
            3'd1:    r = {1'b0, a | b};
            3'd2:    r = {1'b0, ~(a & b)};
            3'd3:    r = {1'b0, ~(a | b)};
            3'd4:    r = {1'b0, ~(a ^ b)};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = {1'b0, ~a};
            default: r = {1'b1, {W{1'b0}}};
        endcase
        return r;
    endfunction

    // Arbitration and operand selection
    always_comb begin
        logic [3:0]     sel;
        logic [N*W-1:0] a_sh;
        logic [N*W-1:0] b_sh;
        logic [N*3-1:0] o_sh;
        sel         = rr_pick(req, rr_ptr);
        pick_vld    = sel[3];
        pick_idx    = sel[2:0];
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        a_sh        = op_a >> (int'(pick_idx) * W);
        b_sh        = op_b >> (int'(pick_idx) * W);
        o_sh        = opcode >> (int'(pick_idx) * 3);
        pick_a      = a_sh[W-1:0];
        pick_b      = b_sh[W-1:0];
        pick_op     = o_sh[2:0];
    end

    // Stage p0: operands captured at the accepting edge
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_vld) begin
            a_p0   <= pick_a;
            b_p0   <= pick_b;
            op_p0  <= pick_op;
            idx_p0 <= pick_idx;
        end
    end

    assign eval_p0 = lu_eval(a_p0, b_p0, op_p0);

    // Stage p1: control FSM and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (pick_vld) begin
                        gnt   <= pick_onehot;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    res_err   <= eval_p0[W];
                    res_data  <= eval_p0[W-1:0];
                    res_id    <= idx_p0;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // Served requester drops to lowest priority.
                        rr_ptr    <= (idx_p0 == 3'(N - 1)) ? 3'd0 : idx_p0 + 3'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N*3-1:0] opcode;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [2:0]     res_id;
    logic           res_err;
    logic           res_ready;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err),
        .res_ready (res_ready)
    );

    typedef struct packed {
        logic [2:0]   id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           model_ptr = 0;
    logic [W-1:0] a_arr[N];
    logic [W-1:0] b_arr[N];
    logic [2:0]   op_arr[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bitwise result straight from the opcode table.
    function automatic exp_t ref_op(int id, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        exp_t e;
        e.id  = 3'(id);
        e.err = 1'b0;
        case (op)
            3'd0: e.data = a & b;
            3'd1: e.data = a | b;
            3'd2: e.data = ~(a & b);
            3'd3: e.data = ~(a | b);
            3'd4: e.data = ~(a ^ b);
            3'd5: e.data = a ^ b;
            3'd6: e.data = ~a;
            default: begin e.data = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Reference: requester with the smallest circular distance from ptr.
    function automatic int ref_winner(logic [N-1:0] mask, int ptr);
        for (int d = 0; d < N; d++) begin
            if (mask[(ptr + d) % N]) return (ptr + d) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W]   = a_arr[i];
            op_b[i*W +: W]   = b_arr[i];
            opcode[i*3 +: 3] = op_arr[i];
        end
    endtask

    task automatic randomize_req(input int i);
        a_arr[i]  = W'($urandom);
        b_arr[i]  = W'($urandom);
        op_arr[i] = 3'($urandom_range(0, 7));
    endtask

    // Waits (bounded) for a grant, checks it against the model and pushes
    // the expected result. rand_rdy toggles res_ready randomly each cycle.
    task automatic await_grant(input bit rand_rdy, output int gcyc, output int win);
        bit seen;
        seen = 1'b0;
        win  = ref_winner(req, model_ptr);
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            if (gnt != '0) seen = 1'b1;
            else if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
        end
        gcyc = cyc;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no gnt expected gnt for requester %0d", win);
        end else begin
            chk("gnt_onehot", 32'(gnt), 32'(1) << win);
            sb.push_back(ref_op(win, a_arr[win], b_arr[win], op_arr[win]));
            model_ptr = (win + 1) % N;
        end
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got res_valid=0 expected 1");
        end
    endtask

    // Monitor: pops and compares on every result handshake and checks that
    // a stalled result stays put.
    bit           hold = 1'b0;
    logic [W-1:0] h_data;
    logic [2:0]   h_id;
    logic         h_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            chk("gnt_with_valid", 32'(gnt != '0 && res_valid), 32'd0);
            if (hold) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_data", 32'(res_data), 32'(h_data));
                chk("hold_id", 32'(res_id), 32'(h_id));
                chk("hold_err", 32'(res_err), 32'(h_err));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got id=%0d data=%0h expected no result", res_id, res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_id", 32'(res_id), 32'(e.id));
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_err", 32'(res_err), 32'(e.err));
                end
            end
            hold   = res_valid && !res_ready;
            h_data = res_data;
            h_id   = res_id;
            h_err  = res_err;
        end
    end

    logic [W-1:0] op_tbl[7];
    logic [N-1:0] rr_tbl[5];

    initial begin
        int g, w, prev_g, hs_cyc;
        op_tbl = '{8'h4A, 8'hDF, 8'hB5, 8'h20, 8'h6A, 8'h95, 8'h35};
        rr_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n     = 1'b0;
        req       = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) randomize_req(i);
        apply();

        // Reset values
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        res_ready = 1'b1;

        // All seven legal ops on requester 2 with the fixed operands
        a_arr[2] = 8'hCA;
        b_arr[2] = 8'h5F;
        for (int op = 0; op < 7; op++) begin
            op_arr[2] = 3'(op);
            apply();
            req = 4'b0100;
            await_grant(1'b0, g, w);
            void'(sb.pop_back());
            sb.push_back('{id: 3'd2, data: op_tbl[op], err: 1'b0});
            req = '0;
            @(posedge clk); #1;
            chk("gnt_pulse", 32'(gnt), 32'd0);
        end

        // Illegal opcode on requester 1
        randomize_req(1);
        op_arr[1] = 3'd7;
        apply();
        req = 4'b0010;
        await_grant(1'b0, g, w);
        void'(sb.pop_back());
        sb.push_back('{id: 3'd1, data: 8'h00, err: 1'b1});
        req = '0;
        repeat (4) @(posedge clk);

        // Asynchronous reset while a result is stalled
        #1 res_ready = 1'b0;
        randomize_req(1);
        apply();
        req = 4'b0010;
        await_grant(1'b0, g, w);
        req = '0;
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_data", 32'(res_data), 32'd0);
        sb.delete();
        model_ptr = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;

        // Round-robin with all requests held
        req    = 4'b1111;
        prev_g = 0;
        for (int k = 0; k < 5; k++) begin
            await_grant(1'b0, g, w);
            chk("rr_seq", 32'(gnt), 32'(rr_tbl[k]));
            if (k > 0) chk("rr_spacing", 32'(g - prev_g), 32'd3);
            prev_g = g;
            randomize_req(w);
            if (k == 4) begin
                req       = '0;
                res_ready = 1'b0;
            end
            apply();
        end

        // Backpressure with requester 3 waiting
        wait_valid();
        req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_no_gnt", 32'(gnt), 32'd0);
            chk("bp_valid", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_gnt", 32'(gnt), 32'd0);
        chk("bp_hs_valid", 32'(res_valid), 32'd0);
        hs_cyc = cyc;
        await_grant(1'b0, g, w);
        chk("bp_gnt_delay", 32'(g - hs_cyc), 32'd1);
        chk("bp_gnt_val", 32'(gnt), 32'b1000);

        // Operand change while the captured op executes
        a_arr[3] = ~a_arr[3];
        b_arr[3] = ~b_arr[3];
        op_arr[3] = 3'($urandom_range(0, 7));
        apply();
        req = '0;
        repeat (4) @(posedge clk);

        // Randomized traffic with random backpressure
        #1;
        for (int i = 0; i < N; i++) randomize_req(i);
        apply();
        req = 4'($urandom_range(1, 15));
        for (int t = 0; t < 300; t++) begin
            await_grant(1'b1, g, w);
            randomize_req(w);
            if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
            if ($urandom_range(0, 3) == 0) req = req | 4'($urandom);
            if (req == '0) req = 4'($urandom_range(1, 15));
            apply();
        end

        req       = '0;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
